// File: rtl/fsk_demod_if.sv
// CPU register-access bus of the FSK demodulator: one-cycle request/acknowledge.
interface fsk_demod_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              valid;
  logic [1:0]        address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, address, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, address, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/fsk_demod.sv
// FSK demodulator: counts limiter rising edges per bit window, decides bits,
// assembles MSB-first bytes, and exposes control/status through a CPU bus.
module fsk_demod #(
  parameter int unsigned DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  fsk_demod_if.slave   bus,
  input  logic         pd,
  input  logic         lim_in
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic        enable;
  logic [15:0] bit_len;
  logic [7:0]  edge_thr;

  logic        sync1, sync2, sync3;
  logic        rise_c;

  logic [1:0]  state, state_nxt;
  logic [15:0] win_cnt, win_nxt;
  logic [7:0]  edge_cnt, edge_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  byte_reg, byte_nxt;
  logic        full, full_nxt;
  logic        overrun, overrun_nxt;

  logic        rd_data_c;
  logic        last_c;
  logic        bit_c;
  logic [15:0] eff_len_c;
  logic [7:0]  cnt_inc_c;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= lim_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise_c    = sync2 & ~sync3;
  assign rd_data_c = bus.valid & ~bus.wstrb & (bus.address == 2'd3);
  assign eff_len_c = (bit_len < 16'd2) ? 16'd2 : bit_len;
  // >= keeps the window bounded if BIT_LEN shrinks below the current count
  assign last_c    = (win_cnt >= (eff_len_c - 16'd1));
  assign cnt_inc_c = (rise_c && (edge_cnt != 8'hFF)) ? (edge_cnt + 8'd1) : edge_cnt;
  assign bit_c     = (cnt_inc_c >= edge_thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      win_cnt  <= 16'd0;
      edge_cnt <= 8'd0;
      shift    <= 8'd0;
      bit_cnt  <= 3'd0;
      byte_reg <= 8'd0;
      full     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      win_cnt  <= win_nxt;
      edge_cnt <= edge_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_reg <= byte_nxt;
      full     <= full_nxt;
      overrun  <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    win_nxt     = win_cnt;
    edge_nxt    = edge_cnt;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    byte_nxt    = byte_reg;
    full_nxt    = full;
    overrun_nxt = overrun;

    if (rd_data_c) begin
      full_nxt    = 1'b0;
      overrun_nxt = 1'b0;
    end

    if (pd || !enable) begin
      state_nxt   = ST_IDLE;
      win_nxt     = 16'd0;
      edge_nxt    = 8'd0;
      shift_nxt   = 8'd0;
      bit_cnt_nxt = 3'd0;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_SYNC;
        ST_SYNC: begin
          if (rise_c) begin
            state_nxt = ST_RUN;
            win_nxt   = 16'd0;
            edge_nxt  = 8'd1;
          end
        end
        ST_RUN: begin
          if (last_c) begin
            win_nxt     = 16'd0;
            edge_nxt    = 8'd0;
            shift_nxt   = {shift[6:0], bit_c};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // A same-cycle DATA read consumes the old byte, so the new one lands
              if (!full || rd_data_c) begin
                byte_nxt    = {shift[6:0], bit_c};
                full_nxt    = 1'b1;
                overrun_nxt = overrun;
              end else begin
                overrun_nxt = 1'b1;
              end
            end
          end else begin
            win_nxt  = win_cnt + 16'd1;
            edge_nxt = cnt_inc_c;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Register file and one-cycle acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      enable    <= 1'b0;
      bit_len   <= 16'd100;
      edge_thr  <= 8'd4;
    end else begin
      bus.ready <= bus.valid;
      bus.rdata <= '0;
      if (bus.valid) begin
        if (bus.wstrb) begin
          case (bus.address)
            2'd0:    enable   <= bus.wdata[0];
            2'd1:    bit_len  <= bus.wdata[15:0];
            2'd2:    edge_thr <= bus.wdata[7:0];
            default: ;
          endcase
        end else begin
          case (bus.address)
            2'd0:    bus.rdata <= DATA_W'(enable);
            2'd1:    bus.rdata <= DATA_W'(bit_len);
            2'd2:    bus.rdata <= DATA_W'(edge_thr);
            default: bus.rdata <= DATA_W'({overrun, full, state, byte_reg});
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fsk_demod.sv
// Directed bench for fsk_demod: register access, byte demodulation, overrun,
// power-down abort, simultaneous read/completion, window boundary and reset.
module tb_fsk_demod;

  logic clk = 1'b0;
  logic rst;
  logic pd;
  logic lim_in;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] rv;

  fsk_demod_if #(.DATA_W(32)) bus ();

  fsk_demod #(.DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pd     (pd),
    .lim_in (lim_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.valid = 1'b1; bus.wstrb = 1'b1; bus.address = a; bus.wdata = d;
    step();
    bus.valid = 1'b0; bus.wstrb = 1'b0;
    check("wr_ready", {31'b0, bus.ready}, 32'd1);
    step();
    check("wr_ready_drop", {31'b0, bus.ready}, 32'd0);
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.valid = 1'b1; bus.wstrb = 1'b0; bus.address = a;
    step();
    bus.valid = 1'b0;
    check({tag, "_ready"}, {31'b0, bus.ready}, 32'd1);
    check(tag, bus.rdata, exp);
    step();
  endtask

  // Limiter waveform for one bit slot of length len at offset o
  function automatic logic wave(input logic b, input int o, input int len);
    if (len == 2) return b && (o == 1);
    if (b) return (o % 20) >= 10;
    return ((o >= 25) && (o < 50)) || (o >= 75);
  endfunction

  // Preamble edge then nbits slots MSB-first; optional DATA read issued at index rd_at
  task automatic send(input logic [15:0] bits, input int nbits, input int len,
                      input int rd_at, output logic [31:0] rd_val);
    rd_val = '0;
    for (int i = 0; i <= len * nbits + 4; i++) begin
      step();
      if (i == rd_at + 1) begin
        check("sim_rd_ready", {31'b0, bus.ready}, 32'd1);
        rd_val = bus.rdata;
        bus.valid = 1'b0;
      end
      if (i == rd_at) begin
        bus.valid = 1'b1; bus.wstrb = 1'b0; bus.address = 2'd3;
      end
      if (i == 0) lim_in = 1'b1;
      else if (i > len * nbits) lim_in = 1'b0;
      else lim_in = wave(bits[nbits - 1 - (i - 1) / len], (i - 1) % len, len);
    end
  endtask

  initial begin
    rst = 1'b1; pd = 1'b0; lim_in = 1'b0;
    bus.valid = 1'b0; bus.wstrb = 1'b0; bus.address = 2'd0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    bus_read("rst_ctrl", 2'd0, 32'h0);
    bus_read("rst_bitlen", 2'd1, 32'd100);
    bus_read("rst_thr", 2'd2, 32'd4);
    bus_read("rst_data", 2'd3, 32'h0);

    // Register read/write
    bus_write(2'd1, 32'h0000_0040);
    bus_write(2'd2, 32'h0000_0005);
    bus_write(2'd0, 32'h0000_0001);
    bus_write(2'd3, 32'h0000_0FFF);
    bus_read("rw_bitlen", 2'd1, 32'h40);
    bus_read("rw_thr", 2'd2, 32'h05);
    bus_read("rw_ctrl", 2'd0, 32'h1);
    bus_read("rw_sync_state", 2'd3, 32'h100);
    bus_write(2'd0, 32'h0);

    // Demodulate 0xA5
    bus_write(2'd1, 32'd100);
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h1);
    send(16'h00A5, 8, 100, -10, rv);
    bus_read("a5_first", 2'd3, 32'h6A5);
    bus_read("a5_second", 2'd3, 32'h2A5);
    bus_write(2'd0, 32'h0);

    // Overrun: 0x3C then 0xFF unread
    bus_write(2'd0, 32'h1);
    send(16'h3CFF, 16, 100, -10, rv);
    bus_read("ovr_first", 2'd3, 32'hE3C);
    bus_read("ovr_second", 2'd3, 32'h23C);
    bus_write(2'd0, 32'h0);

    // Power-down after three bits of 0x81
    bus_write(2'd0, 32'h1);
    send(16'h0004, 3, 100, -10, rv);
    pd = 1'b1;
    step();
    bus_read("pd_idle", 2'd3, 32'h03C);
    pd = 1'b0;
    step();
    send(16'h0081, 8, 100, -10, rv);
    bus_read("pd_byte", 2'd3, 32'h681);
    bus_read("pd_clear", 2'd3, 32'h281);
    bus_write(2'd0, 32'h0);

    // DATA read on the cycle 0x55 completes, 0x12 already held
    bus_write(2'd0, 32'h1);
    send(16'h1255, 16, 100, 1602, rv);
    check("sim_old_byte", rv, 32'h612);
    bus_read("sim_new_byte", 2'd3, 32'h655);
    bus_write(2'd0, 32'h0);

    // BIT_LEN=1 acts as 2; edges only on each window's final cycle, threshold 1
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd1);
    bus_read("bl1_readback", 2'd1, 32'd1);
    bus_write(2'd0, 32'h1);
    send(16'h00B5, 8, 2, -10, rv);
    bus_read("bl1_byte", 2'd3, 32'h6B5);

    // Reset during a pending access
    bus.valid = 1'b1; bus.wstrb = 1'b0; bus.address = 2'd1;
    rst = 1'b1;
    step();
    bus.valid = 1'b0;
    check("mid_rst_ready", {31'b0, bus.ready}, 32'd0);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    step();
    bus_read("mid_rst_ctrl", 2'd0, 32'h0);
    bus_read("mid_rst_bitlen", 2'd1, 32'd100);
    bus_read("mid_rst_data", 2'd3, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
